parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
- Controller that sequences the parity datapath into a serial transmit frame.
- Accepts a data word over a valid/ready handshake and latches the word and its parity config.
- Drives a line-idle-high serial frame: start bit, data LSB-first, optional parity bit, stop bit(s).
- Sits between the parallel producer and the serial pin; the parity computation lives in a small sub-module.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_par_en  in  1  1 = insert parity bit; sampled at handshake
- cfg_par_odd  in  1  1 = odd parity, 0 = even; sampled at handshake
- in_data  in  DATA_W  word to transmit
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept a word
- tx_out  out  1  serial line, idle high
- busy  out  1  frame in progress (any state but IDLE)
- par_bit  out  1  parity bit latched for the current frame
- frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; tx_out=1, in_ready=0 during the reset cycle, busy=0, par_bit=0, frame_done=0.
  - Bit counter and tick counter cleared.
  - Reset mid-frame aborts immediately; the line returns high on the next edge and no frame_done is issued.
- in_ready: 1 only when state==IDLE and rst==0. Combinational from state.
- Handshake:
  - Transfer occurs on a posedge with in_valid && in_ready.
  - At transfer, latch in_data into the shift register and cfg_par_en/cfg_par_odd.
  - At transfer, latch par_bit = (^in_data) ^ cfg_par_odd.
  - Resulting total ones over data+parity is even for even mode, odd for odd mode.
  - in_valid while busy is ignored; the producer holds its word. Input changes while busy have no effect.
- State machine; each non-IDLE state holds its bit for exactly CLKS_PER_BIT cycles, timed by tick_cnt 0..CLKS_PER_BIT-1:
  - IDLE: tx_out=1 -> START on transfer.
  - START: tx_out=0 -> DATA.
  - DATA: tx_out=shreg[0]. Shift right at the end of each bit. bit_cnt runs 0..DATA_W-1. After the last bit -> PARITY if par_en, else STOP.
  - PARITY: tx_out=par_bit -> STOP.
  - STOP: tx_out=1. Repeat STOP_BITS times. frame_done=1 on the final cycle of the last stop bit -> IDLE.
- Latency and throughput:
  - First start-bit cycle is the cycle after the transfer edge.
  - Frame length = (1 + DATA_W + par_en + STOP_BITS) * CLKS_PER_BIT cycles.
  - At least one IDLE cycle between frames, so max throughput is one frame per frame length + 1 cycles.
- CLKS_PER_BIT=1: every state lasts one cycle; the tick counter is degenerate and must not wrap incorrectly.
- tx_out is registered (glitch-free); all outputs except in_ready are registered.
- par_bit holds its value after the frame until the next transfer.

Decomposition:
- Shared package parity_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - PAR_EVEN=0 / PAR_ODD=1 constants
  - function parity_of(word, odd) returning the reduction-XOR-based bit
- Sub-module parity_calc: combinational; inputs data, odd; output bit. Instantiated once on in_data.
- The controller FSM and counters live in parity_frame_tx.

Test Plan (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1):
- Even parity: rst 2 cycles, then in_data=8'hA5, par_en=1, odd=0, one-cycle valid.
  - tx_out sequence 0,1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 4 cycles.
  - frame_done at cycle 44 after transfer; par_bit=0.
- Odd parity: in_data=8'h07, par_en=1, odd=1 -> par_bit=0 (3 ones + 0 = odd). Same word with odd=0 -> par_bit=1.
- Parity disabled: in_data=8'hFF, par_en=0 -> 40-cycle frame, no parity slot; stop follows bit 7 directly.
- Back-to-back: in_valid held high with 8'h01 then 8'h80.
  - Second transfer occurs exactly one IDLE cycle after the first frame_done.
  - in_ready=0 throughout busy; mid-frame in_data changes do not alter tx_out.
- Reset mid-frame: assert rst during DATA bit 3.
  - Next edge: tx_out=1, busy=0, in_ready=0 while rst is high, then 1.
  - No frame_done; a new frame afterwards is transmitted correctly.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared types and helpers for the parity serial transmitter.
//   state_e    : frame controller states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN / PAR_ODD : cfg_par_odd encodings
//   parity_of  : parity bit for a word (zero-extended to PAR_MAX_W bits)
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest word parity_of can take; narrower words are zero-extended,
  // which leaves the reduction XOR unchanged.
  localparam int unsigned PAR_MAX_W = 64;

  // Bit that makes the ones count over word+parity even (odd=0) or odd (odd=1).
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] word,
                                     input logic                 odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// parity_calc: combinational parity generator.
//   data_i    [DATA_W] : word to protect
//   odd_i     [1]      : 1 = odd parity, 0 = even parity
//   par_bit_o [1]      : parity bit for data_i under the selected mode
module parity_calc
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              odd_i,
  output logic              par_bit_o
);

  always_comb begin
    par_bit_o = parity_of(PAR_MAX_W'(data_i), odd_i);
  end

endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: accepts a word over valid/ready and transmits it as a
// line-idle-high serial frame: start bit, data LSB-first, optional parity
// bit, STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT clocks.
//   clk, rst     : system clock (rising edge), synchronous active-high reset
//   cfg_par_en   : insert parity bit (sampled at handshake)
//   cfg_par_odd  : odd parity when 1, even when 0 (sampled at handshake)
//   in_data      : word to transmit
//   in_valid     : producer has a word
//   in_ready     : controller idle and able to accept (combinational)
//   tx_out       : registered serial line, idle high
//   busy         : frame in progress
//   par_bit      : parity bit latched for the current/last frame
//   frame_done   : one-cycle pulse on the final cycle of the last stop bit
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              par_bit,
  output logic              frame_done
);

  localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int unsigned CNT_W  = $clog2(CNT_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                calc_par;
  logic                last_tick;
  logic                xfer;

  parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity_calc (
    .data_i    (in_data),
    .odd_i     (cfg_par_odd),
    .par_bit_o (calc_par)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign xfer      = in_valid && in_ready;
  // With CLKS_PER_BIT=1 TICK_LAST is 0, so every state ends each cycle.
  assign last_tick = (tick_q == TICK_LAST);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = START;
          tick_d    = '0;
          cnt_d     = '0;
          shreg_d   = in_data;
          par_en_d  = cfg_par_en;
          par_bit_d = calc_par;
        end
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          tick_d  = '0;
          cnt_d   = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (last_tick) begin
          tick_d  = '0;
          shreg_d = shreg_q >> 1;
          if (cnt_q == DATA_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_d = STOP;
          tick_d  = '0;
          cnt_d   = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (last_tick) begin
          tick_d = '0;
          if (cnt_q == STOP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed from the next state so that they can be
    // registered without lagging the state by a cycle.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (tick_d == TICK_LAST) && (cnt_d == STOP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign par_bit    = par_bit_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_par_en;
  logic          cfg_par_odd;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx_out;
  logic          busy;
  logic          par_bit;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_out      (tx_out),
    .busy        (busy),
    .par_bit     (par_bit),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          en;
    logic          odd;
    logic          exp_par;
    int            exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Parity from a ones count: the bit that brings the total to the wanted sense.
  function automatic logic model_par(input logic [DW-1:0] d, input logic odd);
    int ones = 0;
    for (int i = 0; i < DW; i++) if (d[i]) ones++;
    return ((ones % 2) == 1) != odd;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_b("ready_timeout", in_ready, 1'b1);
  endtask

  // Called at a negedge; returns right after the transfer edge.
  task automatic send(input logic [DW-1:0] d, input logic en, input logic odd);
    wait_ready();
    in_data     = d;
    cfg_par_en  = en;
    cfg_par_odd = odd;
    in_valid    = 1'b1;
    @(posedge clk);
  endtask

  // Checks one frame cycle by cycle starting just after the transfer edge.
  // After the first sample, inputs are replaced by nd/nen/nodd and in_valid by hold.
  task automatic check_frame(input logic [DW-1:0] d, input logic en, input logic odd,
                             input logic hold, input logic [DW-1:0] nd,
                             input logic nen, input logic nodd, output int done_at);
    logic exp_q[$];
    logic p;
    int   len;
    p       = model_par(d, odd);
    done_at = -1;
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) repeat (CPB) exp_q.push_back(d[i]);
    if (en) repeat (CPB) exp_q.push_back(p);
    repeat (SB * CPB) exp_q.push_back(1'b1);
    len = exp_q.size();
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk_b("tx_out", tx_out, exp_q[c-1]);
      chk_b("busy", busy, 1'b1);
      chk_b("in_ready_busy", in_ready, 1'b0);
      chk_b("frame_done", frame_done, c == len);
      if (frame_done === 1'b1 && done_at < 0) done_at = c;
      if (c == 1) begin
        in_data     = nd;
        cfg_par_en  = nen;
        cfg_par_odd = nodd;
        in_valid    = hold;
      end
    end
    chk_b("par_bit", par_bit, p);
    @(negedge clk);
    chk_b("idle_tx", tx_out, 1'b1);
    chk_b("idle_busy", busy, 1'b0);
    chk_b("idle_ready", in_ready, 1'b1);
    chk_b("idle_done", frame_done, 1'b0);
    chk_b("par_hold", par_bit, p);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            done_at;
    int            bad;
    logic [DW-1:0] d;
    logic          en, odd;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 44};
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 44};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 44};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 40};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 44};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 40};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_b("rst_tx", tx_out, 1'b1);
    chk_b("rst_ready", in_ready, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_par", par_bit, 1'b0);
    chk_b("rst_done", frame_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_b("post_rst_ready", in_ready, 1'b1);
    chk_b("post_rst_tx", tx_out, 1'b1);

    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].en, vecs[i].odd);
      check_frame(vecs[i].data, vecs[i].en, vecs[i].odd, 1'b0,
                  DW'($urandom), 1'($urandom), 1'($urandom), done_at);
      chk_i("tbl_len", done_at, vecs[i].exp_len);
      chk_b("tbl_par", par_bit, vecs[i].exp_par);
    end

    // Back-to-back with in_valid held; in_data switches mid-frame.
    wait_ready();
    in_data = 8'h01; cfg_par_en = 1'b1; cfg_par_odd = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    check_frame(8'h01, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, done_at);
    chk_i("b2b_len", done_at, 44);
    @(posedge clk);
    check_frame(8'h80, 1'b1, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b1, done_at);
    chk_i("b2b_len2", done_at, 44);

    for (int n = 0; n < 20; n++) begin
      d   = DW'($urandom);
      en  = 1'($urandom);
      odd = 1'($urandom);
      send(d, en, odd);
      check_frame(d, en, odd, 1'b0, DW'($urandom), 1'($urandom), 1'($urandom), done_at);
      chk_i("rand_len", done_at, (1 + DW + (en ? 1 : 0) + SB) * CPB);
    end

    // Reset during data bit 3 (frame cycles 17..20).
    d = 8'h5A;
    send(d, 1'b1, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
    end
    chk_b("mid_bit3", tx_out, d[3]);
    rst = 1'b1;
    @(negedge clk);
    chk_b("abort_tx", tx_out, 1'b1);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_ready", in_ready, 1'b0);
    chk_b("abort_done", frame_done, 1'b0);
    chk_b("abort_par", par_bit, 1'b0);
    rst = 1'b0;
    #1;
    chk_b("abort_ready_rel", in_ready, 1'b1);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    chk_i("abort_quiet", bad, 0);
    send(8'hC3, 1'b1, 1'b0);
    check_frame(8'hC3, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, done_at);
    chk_i("after_abort_len", done_at, 44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
